// File: rtl/stacker_row_writer.sv
// stacker_row_writer: stacker game engine for the 8x8 block display.
// Emits the display contents as a stream of row writes
// (write_strobe / row_index / row_data).
// Row 0 is the bottom row. Bit i of a row is column i.
module stacker_row_writer #(
    parameter logic [7:0] INIT_SEG = 8'b00000111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       btn,
    input  logic       tick,
    output logic       write_strobe,
    output logic [2:0] row_index,
    output logic [7:0] row_data,
    output logic [2:0] state,
    output logic [3:0] score
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        PLAY  = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_t;

    state_t      state_reg;
    logic        write_strobe_reg;
    logic [2:0]  row_index_reg;
    logic [7:0]  row_data_reg;
    logic [3:0]  score_reg;
    logic [2:0]  cur_row_reg;
    logic [7:0]  seg_reg;
    logic        dir_reg;      // 1 = moving toward bit 7
    logic [7:0]  below_reg;    // last locked row
    logic [2:0]  clr_cnt_reg;  // next row to clear; wraps to 0 after row 7
    logic        pend_reg;     // write of the fresh row still owed

    logic [7:0]  locked_next;
    logic [7:0]  moved_seg_next;
    logic        moved_dir_next;

    assign write_strobe = write_strobe_reg;
    assign row_index    = row_index_reg;
    assign row_data     = row_data_reg;
    assign state        = state_reg;
    assign score        = score_reg;

    // Row produced by a lock: the bottom row keeps the whole segment,
    // higher rows keep only the overlap with the row underneath.
    always_comb begin
        locked_next = (cur_row_reg == 3'd0) ? seg_reg : (seg_reg & below_reg);
    end

    // One bounce step: reverse at either edge, otherwise shift toward dir.
    always_comb begin
        moved_dir_next = dir_reg;
        moved_seg_next = seg_reg;
        if (dir_reg && seg_reg[7]) begin
            moved_dir_next = 1'b0;
            moved_seg_next = seg_reg >> 1;
        end else if (!dir_reg && seg_reg[0]) begin
            moved_dir_next = 1'b1;
            moved_seg_next = seg_reg << 1;
        end else if (dir_reg) begin
            moved_seg_next = seg_reg << 1;
        end else begin
            moved_seg_next = seg_reg >> 1;
        end
    end

    // Game FSM with registered row-write outputs.
    // Each write is issued on the edge that leaves the deciding cycle,
    // so the row-0 clear goes out as CLEAR is entered and the initial
    // segment write goes out as PLAY is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            write_strobe_reg <= 1'b0;
            row_index_reg    <= 3'd0;
            row_data_reg     <= 8'd0;
            score_reg        <= 4'd0;
            cur_row_reg      <= 3'd0;
            seg_reg          <= INIT_SEG;
            dir_reg          <= 1'b1;
            below_reg        <= 8'd0;
            clr_cnt_reg      <= 3'd0;
            pend_reg         <= 1'b0;
        end else begin
            write_strobe_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg        <= CLEAR;
                        write_strobe_reg <= 1'b1;
                        row_index_reg    <= 3'd0;
                        row_data_reg     <= 8'd0;
                        clr_cnt_reg      <= 3'd1;
                    end
                end
                CLEAR: begin
                    if (!start) begin
                        state_reg <= IDLE;
                    end else if (clr_cnt_reg == 3'd0) begin
                        // All eight rows cleared: enter PLAY and emit the
                        // owed initial segment write on the same edge.
                        state_reg        <= PLAY;
                        cur_row_reg      <= 3'd0;
                        seg_reg          <= INIT_SEG;
                        dir_reg          <= 1'b1;
                        score_reg        <= 4'd0;
                        below_reg        <= 8'd0;
                        pend_reg         <= 1'b0;
                        write_strobe_reg <= 1'b1;
                        row_index_reg    <= 3'd0;
                        row_data_reg     <= INIT_SEG;
                    end else begin
                        write_strobe_reg <= 1'b1;
                        row_index_reg    <= clr_cnt_reg;
                        row_data_reg     <= 8'd0;
                        clr_cnt_reg      <= clr_cnt_reg + 3'd1;
                    end
                end
                PLAY: begin
                    if (!start) begin
                        state_reg <= IDLE;
                    end else if (pend_reg) begin
                        pend_reg         <= 1'b0;
                        write_strobe_reg <= 1'b1;
                        row_index_reg    <= cur_row_reg;
                        row_data_reg     <= seg_reg;
                    end else if (btn) begin
                        write_strobe_reg <= 1'b1;
                        row_index_reg    <= cur_row_reg;
                        row_data_reg     <= locked_next;
                        if (locked_next == 8'd0) begin
                            state_reg <= LOSE;
                        end else begin
                            score_reg <= score_reg + 4'd1;
                            if (cur_row_reg == 3'd7) begin
                                state_reg <= WIN;
                            end else begin
                                cur_row_reg <= cur_row_reg + 3'd1;
                                below_reg   <= locked_next;
                                seg_reg     <= locked_next;
                                pend_reg    <= 1'b1;
                            end
                        end
                    end else if (tick) begin
                        seg_reg          <= moved_seg_next;
                        dir_reg          <= moved_dir_next;
                        write_strobe_reg <= 1'b1;
                        row_index_reg    <= cur_row_reg;
                        row_data_reg     <= moved_seg_next;
                    end
                end
                WIN, LOSE: begin
                    if (!start) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stacker_row_writer.sv
// Self-checking bench for stacker_row_writer: directed game scenarios with
// literal expectations plus randomized play against an interval-based model.
module tb_stacker_row_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       btn = 1'b0;
    logic       tick = 1'b0;
    logic       write_strobe;
    logic [2:0] row_index;
    logic [7:0] row_data;
    logic [2:0] state;
    logic [3:0] score;

    stacker_row_writer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .btn          (btn),
        .tick         (tick),
        .write_strobe (write_strobe),
        .row_index    (row_index),
        .row_data     (row_data),
        .state        (state),
        .score        (score)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Expected outputs after the next clock edge.
    bit exp_strobe;
    int exp_idx, exp_data, exp_state, exp_score;

    // Game model: the segment is an interval [lo, lo+w) of lit columns.
    int m_mode;        // 0 idle, 1 clear, 2 play, 3 win, 4 lose
    int m_clr;         // rows already cleared
    int m_row;
    int m_lo, m_w;
    bit m_up;          // moving toward column 7
    int m_blo, m_bw;   // interval of the row below
    bit m_pend;
    int m_score;

    function automatic logic [7:0] seg_of(input int lo, input int w);
        logic [15:0] v;
        if (w <= 0) return 8'd0;
        v = ((16'd1 << w) - 16'd1) << lo;
        return v[7:0];
    endfunction

    task automatic wr(input int r, input int d);
        exp_strobe = 1'b1;
        exp_idx    = r;
        exp_data   = d;
    endtask

    task automatic model_reset();
        m_mode = 0; m_clr = 0; m_row = 0; m_lo = 0; m_w = 3; m_up = 1'b1;
        m_blo = 0; m_bw = 0; m_pend = 1'b0; m_score = 0;
        exp_strobe = 1'b0; exp_idx = 0; exp_data = 0; exp_state = 0; exp_score = 0;
    endtask

    task automatic model_step(input bit s, input bit b, input bit t);
        int nlo, nhi, nw;
        exp_strobe = 1'b0;
        case (m_mode)
            0: if (s) begin m_mode = 1; m_clr = 1; wr(0, 0); end
            1: begin
                if (!s) m_mode = 0;
                else if (m_clr == 8) begin
                    m_mode = 2; m_row = 0; m_lo = 0; m_w = 3; m_up = 1'b1;
                    m_score = 0; m_pend = 1'b0;
                    wr(0, 'h07);
                end else begin
                    wr(m_clr, 0);
                    m_clr++;
                end
            end
            2: begin
                if (!s) m_mode = 0;
                else if (m_pend) begin
                    wr(m_row, seg_of(m_lo, m_w));
                    m_pend = 1'b0;
                end else if (b) begin
                    if (m_row == 0) begin
                        nlo = m_lo; nw = m_w;
                    end else begin
                        nlo = (m_lo > m_blo) ? m_lo : m_blo;
                        nhi = ((m_lo + m_w) < (m_blo + m_bw)) ? (m_lo + m_w) : (m_blo + m_bw);
                        nw  = nhi - nlo;
                    end
                    wr(m_row, seg_of(nlo, nw));
                    if (nw <= 0) m_mode = 4;
                    else begin
                        m_score++;
                        if (m_row == 7) m_mode = 3;
                        else begin
                            m_row++;
                            m_blo = nlo; m_bw = nw; m_lo = nlo; m_w = nw;
                            m_pend = 1'b1;
                        end
                    end
                end else if (t) begin
                    if (m_up) begin
                        if (m_lo + m_w == 8) begin m_up = 1'b0; m_lo--; end
                        else m_lo++;
                    end else begin
                        if (m_lo == 0) begin m_up = 1'b1; m_lo++; end
                        else m_lo--;
                    end
                    wr(m_row, seg_of(m_lo, m_w));
                end
            end
            default: if (!s) m_mode = 0;
        endcase
        exp_state = m_mode;
        exp_score = m_score;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            tests++;
            if (write_strobe !== exp_strobe || row_index !== exp_idx[2:0] ||
                row_data !== exp_data[7:0] || state !== exp_state[2:0] ||
                score !== exp_score[3:0]) begin
                fails++;
                $display("FAIL model t=%0t got stb=%0b row=%0d data=%02h st=%0d sc=%0d want stb=%0b row=%0d data=%02h st=%0d sc=%0d",
                         $time, write_strobe, row_index, row_data, state, score,
                         exp_strobe, exp_idx, exp_data, exp_state, exp_score);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, advance the model, return just after the edge.
    task automatic cyc(input bit r, input bit s, input bit b, input bit t);
        @(negedge clk);
        #1;
        reset = r; start = s; btn = b; tick = t;
        if (r) model_reset();
        else model_step(s, b, t);
        check_en = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic start_game();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (9) cyc(0, 1, 0, 0);
        chk("game_state", int'(state), 2);
        chk("game_row0", int'(row_data), 'h07);
    endtask

    int bl[11] = '{'h0E, 'h1C, 'h38, 'h70, 'hE0, 'h70, 'h38, 'h1C, 'h0E, 'h07, 'h0E};

    initial begin
        model_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_state", int'(state), 0);
        chk("rst_strobe", int'(write_strobe), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_data", int'(row_data), 0);

        // Clear sequence.
        cyc(0, 1, 0, 0);
        chk("clr_state", int'(state), 1);
        chk("clr0_strobe", int'(write_strobe), 1);
        chk("clr0_row", int'(row_index), 0);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 1, 0, 0);
            chk("clr_strobe", int'(write_strobe), 1);
            chk("clr_row", int'(row_index), i);
            chk("clr_data", int'(row_data), 0);
        end
        cyc(0, 1, 0, 0);
        chk("play_state", int'(state), 2);
        chk("play_strobe", int'(write_strobe), 1);
        chk("play_row", int'(row_index), 0);
        chk("play_data", int'(row_data), 'h07);

        // Bounce across and back.
        for (int i = 0; i < 11; i++) begin
            cyc(0, 1, 0, 1);
            chk("bounce_data", int'(row_data), bl[i]);
        end

        // Partial lock.
        start_game();
        cyc(0, 1, 1, 0);
        chk("pl_score1", int'(score), 1);
        cyc(0, 1, 0, 0);
        chk("pl_pend_row", int'(row_index), 1);
        cyc(0, 1, 0, 1);
        chk("pl_tick", int'(row_data), 'h0E);
        cyc(0, 1, 1, 0);
        chk("pl_lock_row", int'(row_index), 1);
        chk("pl_lock_data", int'(row_data), 'h06);
        chk("pl_score2", int'(score), 2);
        cyc(0, 1, 0, 0);
        chk("pl_next_row", int'(row_index), 2);
        chk("pl_next_data", int'(row_data), 'h06);

        // Miss -> LOSE.
        start_game();
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 1);
        chk("miss_pos", int'(row_data), 'h38);
        cyc(0, 1, 1, 0);
        chk("miss_data", int'(row_data), 0);
        chk("miss_strobe", int'(write_strobe), 1);
        chk("miss_state", int'(state), 4);
        chk("miss_score", int'(score), 1);
        cyc(0, 1, 1, 1);
        chk("lose_quiet", int'(write_strobe), 0);
        cyc(0, 1, 0, 1);
        chk("lose_quiet2", int'(write_strobe), 0);

        // Win without moving.
        start_game();
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 1, 0);
            chk("win_row", int'(row_index), i);
            chk("win_data", int'(row_data), 'h07);
            chk("win_score", int'(score), i + 1);
            if (i < 7) cyc(0, 1, 0, 0);
        end
        chk("win_state", int'(state), 3);
        cyc(0, 1, 1, 1);
        chk("win_quiet", int'(write_strobe), 0);
        chk("win_hold", int'(score), 8);
        cyc(0, 0, 0, 0);
        chk("win_idle", int'(state), 0);

        // Simultaneous btn and tick: lock only.
        start_game();
        cyc(0, 1, 1, 1);
        chk("sim_data", int'(row_data), 'h07);
        chk("sim_row", int'(row_index), 0);
        cyc(0, 1, 0, 0);
        chk("sim_pend", int'(row_index), 1);

        // Abort during CLEAR.
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("abort_state", int'(state), 0);
        chk("abort_strobe", int'(write_strobe), 0);
        cyc(0, 0, 0, 0);
        chk("abort_quiet", int'(write_strobe), 0);

        // Asynchronous reset mid-PLAY.
        start_game();
        cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 0);
        reset = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_strobe", int'(write_strobe), 0);
        chk("arst_score", int'(score), 0);
        chk("arst_row", int'(row_index), 0);
        chk("arst_data", int'(row_data), 0);
        model_reset();
        cyc(1, 0, 0, 0);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 499) == 0,
                $urandom_range(0, 63) != 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) == 0);
        end

        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
